opacc_seq: RTL and testbench

Self-sequenced outer-product accumulator; successor to the opacc + shift_fsm pair. Owns an ML x VL tile of XLEN-bit accumulators and an internal FSM. Per command it optionally loads or zeroes the tile, then accumulates K outer products (C += A*B or C -= A*B). It then drains the tile row by row.
All streams use valid/ready handshakes. Sits between the vector register read ports and the matrix result writeback in the MPU.

---
 rtl/opacc_seq.sv | 147 ++++++++++++++
 tb/tb_opacc_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/opacc_seq.sv
// opacc_seq: self-sequenced ML x VL outer-product accumulator.
// Optional C load or clear, K rank-1 updates, then a row-wise drain.
module opacc_seq #(
  parameter int XLEN = 64,
  parameter int VLEN = 128,
  parameter int MLEN = 128,
  parameter int KW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [KW-1:0]        cmd_k,
  input  logic                 cmd_load_c,
  input  logic                 cmd_sub,
  input  logic                 c_valid,
  output logic                 c_ready,
  input  logic [VLEN-1:0]      vi_c,
  input  logic                 ab_valid,
  output logic                 ab_ready,
  input  logic [MLEN-1:0]      vi_a,
  input  logic [VLEN-1:0]      vi_b,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [VLEN-1:0]      vo_c,
  output logic                 o_last,
  output logic                 busy
);

  localparam int VL = VLEN / XLEN;
  localparam int ML = MLEN / XLEN;
  localparam int RW = (ML > 1) ? $clog2(ML) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ML - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_C,
    ACC,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [RW-1:0]   row;
  logic [KW-1:0]   k;
  logic            sub;
  logic [XLEN-1:0] reg_c [ML][VL];

  logic cmd_hs, c_hs, ab_hs, o_hs;
  logic row_last;

  assign cmd_hs   = cmd_valid & cmd_ready;
  assign c_hs     = c_valid & c_ready;
  assign ab_hs    = ab_valid & ab_ready;
  assign o_hs     = o_valid & o_ready;
  assign row_last = (row == ROW_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_hs) begin
          if (cmd_load_c)         state_nxt = LOAD_C;
          else if (cmd_k != '0)   state_nxt = ACC;
          else                    state_nxt = DRAIN;
        end
      end
      LOAD_C: begin
        if (c_hs && row_last)
          state_nxt = (k != '0) ? ACC : DRAIN;
      end
      ACC: begin
        if (ab_hs && k == KW'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (o_hs && row_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and drain outputs decoded from state
  always_comb begin
    cmd_ready = (state == IDLE);
    c_ready   = (state == LOAD_C);
    ab_ready  = (state == ACC);
    o_valid   = (state == DRAIN);
    busy      = (state != IDLE);
    o_last    = (state == DRAIN) && row_last;
    vo_c      = '0;
    if (state == DRAIN) begin
      for (int j = 0; j < VL; j++)
        vo_c[j*XLEN +: XLEN] = reg_c[row][j];
    end
  end

  // Tile, row counter and command fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      k   <= '0;
      sub <= 1'b0;
      for (int i = 0; i < ML; i++)
        for (int j = 0; j < VL; j++)
          reg_c[i][j] <= '0;
    end else begin
      if (cmd_hs) begin
        k   <= cmd_k;
        sub <= cmd_sub;
        row <= '0;
        if (!cmd_load_c) begin
          for (int i = 0; i < ML; i++)
            for (int j = 0; j < VL; j++)
              reg_c[i][j] <= '0;
        end
      end
      if (c_hs) begin
        for (int j = 0; j < VL; j++)
          reg_c[row][j] <= vi_c[j*XLEN +: XLEN];
        row <= row_last ? '0 : row + RW'(1);
      end
      if (ab_hs) begin
        for (int i = 0; i < ML; i++)
          for (int j = 0; j < VL; j++)
            if (sub)
              reg_c[i][j] <= reg_c[i][j]
                - vi_a[i*XLEN +: XLEN] * vi_b[j*XLEN +: XLEN];
            else
              reg_c[i][j] <= reg_c[i][j]
                + vi_a[i*XLEN +: XLEN] * vi_b[j*XLEN +: XLEN];
        k <= k - KW'(1);
        if (k == KW'(1)) row <= '0;
      end
      if (o_hs) begin
        row <= row_last ? '0 : row + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_opacc_seq.sv
// tb_opacc_seq: directed and random checks of opacc_seq
// against a plain-arithmetic tile model.
module tb_opacc_seq;

  localparam int XLEN = 64;
  localparam int VLEN = 128;
  localparam int MLEN = 128;
  localparam int KW   = 8;
  localparam int VL   = VLEN / XLEN;
  localparam int ML   = MLEN / XLEN;
  localparam int W    = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid, cmd_ready;
  logic [KW-1:0]   cmd_k;
  logic            cmd_load_c, cmd_sub;
  logic            c_valid, c_ready;
  logic [VLEN-1:0] vi_c;
  logic            ab_valid, ab_ready;
  logic [MLEN-1:0] vi_a;
  logic [VLEN-1:0] vi_b;
  logic            o_valid, o_ready;
  logic [VLEN-1:0] vo_c;
  logic            o_last, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [XLEN-1:0] m [ML][VL];
  bit              cur_sub;

  opacc_seq #(
    .XLEN(XLEN), .VLEN(VLEN), .MLEN(MLEN), .KW(KW)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_k(cmd_k), .cmd_load_c(cmd_load_c), .cmd_sub(cmd_sub),
    .c_valid(c_valid), .c_ready(c_ready), .vi_c(vi_c),
    .ab_valid(ab_valid), .ab_ready(ab_ready),
    .vi_a(vi_a), .vi_b(vi_b),
    .o_valid(o_valid), .o_ready(o_ready),
    .vo_c(vo_c), .o_last(o_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mrow(input int r);
    logic [W-1:0] v = '0;
    for (int j = 0; j < VL; j++) v[j*XLEN +: XLEN] = m[r][j];
    return v;
  endfunction

  function automatic logic [W-1:0] pack2(input logic [63:0] e0,
                                         input logic [63:0] e1);
    return {e1, e0};
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ML; i++)
      for (int j = 0; j < VL; j++) m[i][j] = '0;
  endtask

  task automatic send_cmd(input int k, input bit ld, input bit sb);
    int n = 0;
    cmd_valid = 1'b1; cmd_k = k[KW-1:0];
    cmd_load_c = ld; cmd_sub = sb;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cur_sub = sb;
    if (!ld) model_clear();
  endtask

  task automatic send_c(input int r, input logic [W-1:0] row);
    int n = 0;
    c_valid = 1'b1; vi_c = row;
    while (!c_ready && n < 100) begin @(negedge clk); n++; end
    check("c_ready_wait", c_ready, 1);
    @(negedge clk);
    c_valid = 1'b0;
    for (int j = 0; j < VL; j++) m[r][j] = row[j*XLEN +: XLEN];
  endtask

  task automatic send_ab(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap);
    int n = 0;
    ab_valid = 1'b0;
    repeat (gap) @(negedge clk);
    ab_valid = 1'b1; vi_a = a; vi_b = b;
    while (!ab_ready && n < 100) begin @(negedge clk); n++; end
    check("ab_ready_wait", ab_ready, 1);
    @(negedge clk);
    ab_valid = 1'b0;
    for (int i = 0; i < ML; i++)
      for (int j = 0; j < VL; j++) begin
        logic [63:0] p = a[i*XLEN +: XLEN] * b[j*XLEN +: XLEN];
        m[i][j] = cur_sub ? m[i][j] - p : m[i][j] + p;
      end
  endtask

  task automatic drain(input int stall0, input bit rnd);
    for (int r = 0; r < ML; r++) begin
      int n = 0;
      int s;
      o_ready = 1'b0;
      while (!o_valid && n < 100) begin @(negedge clk); n++; end
      check("o_valid_wait", o_valid, 1);
      s = rnd ? int'($urandom_range(0, 2)) : ((r == 0) ? stall0 : 0);
      for (int t = 0; t < s; t++) begin
        check("stall_vo_c", vo_c, mrow(r));
        check("stall_o_last", o_last, (r == ML - 1));
        @(negedge clk);
      end
      o_ready = 1'b1;
      check("drain_vo_c", vo_c, mrow(r));
      check("drain_o_last", o_last, (r == ML - 1));
      @(negedge clk);
      o_ready = 1'b0;
    end
    check("post_drain_cmd_ready", cmd_ready, 1);
    check("post_drain_busy", busy, 0);
  endtask

  initial begin
    int nb;
    reset = 1'b1;
    cmd_valid = 0; cmd_k = '0; cmd_load_c = 0; cmd_sub = 0;
    c_valid = 0; vi_c = '0; ab_valid = 0; vi_a = '0; vi_b = '0;
    o_ready = 0; cur_sub = 0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_c_ready", c_ready, 0);
    check("rst_ab_ready", ab_ready, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_last", o_last, 0);
    check("rst_vo_c", vo_c, 0);
    check("rst_busy", busy, 0);

    // load, k=3 add; ab_valid held high during load must be ignored
    send_cmd(3, 1, 0);
    ab_valid = 1'b1; vi_a = pack2(99, 99); vi_b = pack2(99, 99);
    send_c(0, pack2(1, 2));
    ab_valid = 1'b1;
    send_c(1, pack2(3, 4));
    for (int p = 0; p < 3; p++) send_ab(pack2(1, 2), pack2(1, 1), 0);
    check("tp1_model_row0", mrow(0), pack2(4, 5));
    check("tp1_model_row1", mrow(1), pack2(9, 10));
    drain(0, 0);

    // clear with k=0 goes straight to drain
    o_ready = 1'b1;
    send_cmd(0, 0, 0);
    nb = 0;
    while (busy && nb < 10) begin
      check("k0_vo_c", vo_c, 0);
      nb++;
      @(negedge clk);
    end
    check("k0_busy_cycles", nb, ML);
    o_ready = 1'b0;

    // subtract with wrap
    send_cmd(1, 1, 1);
    send_c(0, pack2(5, 5));
    send_c(1, pack2(5, 5));
    send_ab(pack2(2, 3), pack2(1, 2), 0);
    check("sub_model_row1", mrow(1), pack2(2, 64'hFFFF_FFFF_FFFF_FFFF));
    drain(0, 0);

    // ab_valid gaps and drain backpressure
    send_cmd(2, 1, 0);
    send_c(0, pack2(7, 8));
    send_c(1, pack2(9, 10));
    send_ab(pack2(3, 4), pack2(5, 6), 0);
    send_ab(pack2(2, 1), pack2(1, 3), 1);
    drain(4, 0);

    // async reset in the middle of accumulation
    send_cmd(3, 0, 0);
    send_ab(pack2(1, 1), pack2(1, 1), 0);
    #2 reset = 1'b1;
    #1;
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_ab_ready", ab_ready, 0);
    check("arst_o_valid", o_valid, 0);
    check("arst_vo_c", vo_c, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    send_cmd(0, 0, 0);
    drain(0, 0);

    // overflow wrap
    send_cmd(1, 0, 0);
    send_ab(pack2(64'h8000_0000_0000_0000, 1), pack2(2, 1), 0);
    check("ovf_model_row0", mrow(0), pack2(0, 64'h8000_0000_0000_0000));
    drain(0, 0);

    // random commands
    for (int it = 0; it < 20; it++) begin
      int k = $urandom_range(0, 4);
      bit ld = 1'($urandom_range(0, 1));
      bit sb = 1'($urandom_range(0, 1));
      send_cmd(k, ld, sb);
      if (ld) for (int r = 0; r < ML; r++) send_c(r, rnd128());
      for (int p = 0; p < k; p++)
        send_ab(rnd128(), rnd128(), $urandom_range(0, 2));
      drain(0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
